// File: rtl/sequenciador_zonas_pkg.sv
// Shared types for the staggered zone power-on scheduler.
package seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } seq_estado_t;

endpackage

// File: rtl/sequenciador_zonas_if.sv
// Request/grant bus between the zone controllers and the relay scheduler.
// master: zone-controller side (drives req); slave: scheduler side.
interface sequenciador_zonas_if #(
  parameter int N_ZONAS = 4
);
  localparam int NW = $clog2(N_ZONAS + 1);

  logic [N_ZONAS-1:0] req;
  logic [N_ZONAS-1:0] grant;
  logic               espera;
  logic [NW-1:0]      n_ativas;
  logic               ocupado;

  modport master (output req, input grant, espera, n_ativas, ocupado);
  modport slave  (input req, output grant, espera, n_ativas, ocupado);
endinterface

// File: rtl/sequenciador_zonas_seletor.sv
// Combinational zone selector: first pending zone scanning upward from ptr
// with wrap-around. Build macro ZONA_PRIORIDADE_FIXA_EN switches to fixed
// priority (lowest pending index wins) and ignores ptr.
module seletor_rr #(
  parameter int N_ZONAS = 4,
  localparam int PW = $clog2(N_ZONAS)
) (
  input  logic [N_ZONAS-1:0] pend,
  input  logic [PW-1:0]      ptr,
  output logic [N_ZONAS-1:0] sel,
  output logic [PW-1:0]      k
);

`ifdef ZONA_PRIORIDADE_FIXA_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  logic [PW-1:0] idx;
  logic          achou;

  // Scan all candidate positions once; the first pending one wins.
  always_comb begin
    sel   = '0;
    k     = '0;
    idx   = '0;
    achou = 1'b0;
    for (int i = 0; i < N_ZONAS; i++) begin
`ifdef ZONA_PRIORIDADE_FIXA_EN
      idx = PW'(i);
`else
      idx = PW'((int'(ptr) + i) % N_ZONAS);
`endif
      if (!achou && pend[idx]) begin
        achou    = 1'b1;
        sel[idx] = 1'b1;
        k        = idx;
      end
    end
  end

endmodule

// File: rtl/sequenciador_zonas.sv
// Staggered power-on scheduler: limits concurrent zones to MAX_ON and spaces
// successive turn-ons by STAGGER_T cycles of HOLD.
// Optional build macro: ZONA_PRIORIDADE_FIXA_EN (fixed priority, no ptr).
module sequenciador_zonas
  import seq_pkg::*;
#(
  parameter int N_ZONAS   = 4,
  parameter int STAGGER_T = 1000,
  parameter int MAX_ON    = 3
) (
  input logic                  clk,
  input logic                  rst,
  sequenciador_zonas_if.slave  bus
);

  localparam int PW = $clog2(N_ZONAS);
  localparam int CW = $clog2(STAGGER_T + 1);
  localparam int NW = $clog2(N_ZONAS + 1);

  seq_estado_t        estado;
  logic [CW-1:0]      cnt;
  logic [PW-1:0]      ptr;
  logic [N_ZONAS-1:0] grant_q;
  logic [N_ZONAS-1:0] pend;
  logic [N_ZONAS-1:0] sel;
  logic [PW-1:0]      k;
  logic [NW-1:0]      n_at;
  logic               concede;

  assign pend = bus.req & ~grant_q;

  // Popcount of the registered grant vector drives the budget check.
  always_comb begin
    n_at = '0;
    for (int i = 0; i < N_ZONAS; i++) n_at = n_at + NW'(grant_q[i]);
  end

  assign concede = (estado == IDLE) && (|pend) && (n_at < NW'(MAX_ON));

  seletor_rr #(.N_ZONAS(N_ZONAS)) u_sel (
    .pend (pend),
    .ptr  (ptr),
    .sel  (sel),
    .k    (k)
  );

  // FSM and stagger counter; release of grants never touches these.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado <= IDLE;
      cnt    <= '0;
    end else begin
      case (estado)
        IDLE: if (concede) begin
          estado <= HOLD;
          cnt    <= '0;
        end
        HOLD: if (cnt == CW'(STAGGER_T - 1)) begin
          estado <= IDLE;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: estado <= IDLE;
      endcase
    end
  end

  // Grants drop as soon as their request drops; one new grant per IDLE issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) grant_q <= '0;
    else      grant_q <= (grant_q & bus.req) | (concede ? sel : '0);
  end

`ifdef ZONA_PRIORIDADE_FIXA_EN
  assign ptr = '0;
`else
  // Round-robin pointer moves just past the zone that was granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         ptr <= '0;
    else if (concede) ptr <= (k == PW'(N_ZONAS - 1)) ? '0 : k + 1'b1;
  end
`endif

  assign bus.grant    = grant_q;
  assign bus.espera   = |pend;
  assign bus.n_ativas = n_at;
  assign bus.ocupado  = (estado == HOLD);

endmodule

// File: doc/sequenciador_zonas.md
# sequenciador_zonas

- Staggered power-on scheduler for up to `N_ZONAS` lighting zones that share one supply circuit.
- Each zone's `controladora` requests its lamp through its `saida` output. This block decides which relays are driven, and when.
- It limits the number of zones that may be on at once, and spaces successive turn-ons to bound inrush current.
- It sits between the per-zone controllers and the relay drivers.

## Interface
- `N_ZONAS`, default 4: number of zones. Legal range is 2..16.
- `STAGGER_T`, default 1000: number of cycles spent in HOLD after each grant. Must be ≥1.
- `MAX_ON`, default 3: maximum number of concurrently granted zones. Legal range is 1..`N_ZONAS`.

Ports:
- `clk`  in  1: single clock. All state changes on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `req`  in  `N_ZONAS`: zone on-requests, from each `controladora` `saida`. Level-sensitive.
- `grant`  out  `N_ZONAS`: relay drive, registered.
- `espera`  out  1: at least one request is pending, i.e. `|(req & ~grant)`. Combinational.
- `n_ativas`  out  `$clog2(N_ZONAS+1)`: popcount of `grant`. Combinational.
- `ocupado`  out  1: high while the state is HOLD.

## Operation
**Pending set**
- `pend = req & ~grant`.
- Requests are not latched: a request that rises and falls before being granted is forgotten.

**Release**
- If `req[i]=0` and `grant[i]=1`, then `grant[i]` clears at the next edge.
- Release happens in any state and does not affect the FSM or the counter.

**Budget**
- The budget check uses the popcount of the current registered `grant`.
- A release occurring on the same edge does not free budget until the following cycle.

**FSM states: IDLE and HOLD**
- **IDLE:** if `pend≠0` and `n_ativas<MAX_ON`, then on the next edge:
  - Set `grant[k]`, where `k` is the selected zone.
  - Set `ptr ← (k+1) mod N_ZONAS`.
  - Set `cnt ← 0` and go to HOLD.
  - Otherwise, stay in IDLE.
- **HOLD:**
  - `cnt` increments each cycle.
  - On the edge where `cnt==STAGGER_T-1`, go to IDLE and clear `cnt`.
  - No new grant is issued in HOLD.
- **Selection (round-robin):** choose the first set bit of `pend` scanning upward from `ptr`, with wrap-around.
- **Granted zone releases during HOLD:** the grant clears normally and HOLD still runs to completion.

**Arithmetic**
- `cnt` is `$clog2(STAGGER_T+1)` bits wide and never wraps.
- `ptr` is `$clog2(N_ZONAS)` bits wide, with an explicit modulo.

## Timing
**Reset values**
- `grant=0`, `ptr=0`, `cnt=0`, state IDLE.
- As a result: `espera=|req`, `n_ativas=0`, `ocupado=0`.
- Reset clears all grants immediately and asynchronously, including in the middle of HOLD.

**Latency**
- Request to grant, when IDLE and budget is free: 1 edge.
- Release: 1 edge.

**Spacing**
- Minimum interval between two grant rising edges: `STAGGER_T+1` cycles.
- That is `STAGGER_T` cycles in HOLD, plus 1 in IDLE.

**Budget-blocked zones**
- When the budget is full, a pending zone is granted 1 edge after `n_ativas` drops below `MAX_ON`, provided the state is IDLE.

## Configuration
- `ZONA_PRIORIDADE_FIXA_EN`:
  - **Defined:** fixed priority, where the lowest pending index wins. `ptr` is not implemented.
  - **Undefined (default):** round-robin as described in Operation.
- All other behaviour is identical in both builds.

## Structure
- Package `seq_pkg` holds the FSM state enum typedef `seq_estado_t` (IDLE, HOLD).
- `seletor_rr` is a combinational sub-module:
  - Inputs: `pend` and `ptr`.
  - Outputs: one-hot `sel` and index `k`.
  - It contains the `ZONA_PRIORIDADE_FIXA_EN` variant.
- The FSM, counter, grant register and popcount stay in `sequenciador_zonas`.

## Test plan
All scenarios use `N_ZONAS=4`, `STAGGER_T=4`, `MAX_ON=3`.

1. **Idle after reset:** release reset with `req=0000` → `grant=0000`, `espera=0`, `ocupado=0`, `n_ativas=0`.
2. **Staggered turn-on:** raise `req=1111` before edge 1 →
   - `grant[0]` after edge 1, `grant[1]` after edge 6, `grant[2]` after edge 11.
   - `grant[3]` stays 0 and `espera=1` while `n_ativas=3`.
3. **Budget release:** continuing from scenario 2, drop `req[0]` →
   - `grant[0]` clears 1 edge later.
   - `grant[3]` sets on the following edge (state IDLE).
   - `ptr` wraps to 0.
4. **Round-robin fairness:** with `ptr=2`, `grant=0000` and `req=0011` → `grant[0]` is granted first, then `grant[1]` 5 cycles later.
5. **Reset mid-operation:** assert `rst=0` while in HOLD with `cnt=2` →
   - `grant=0000` immediately, without waiting for a clock edge.
   - After release, state is IDLE with `cnt=0`.
6. **Fixed-priority build:** with `ZONA_PRIORIDADE_FIXA_EN` defined, `ptr` state equivalent to 2, and `req=0101` → zone 0 is granted first.
7. **Short request:** a `req[1]` pulse that lasts only within a HOLD window → never granted, and `espera` falls when the pulse falls.
